reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
Shares the single register-file write port between the main datapath writeback and an auxiliary multi-cycle result source, such as a mult/div unit or a late load return.
- Main writeback has priority and no backpressure.
- Auxiliary results are buffered in a small FIFO, drained into idle write slots, and forced through by a starvation stall.
- A pending-destination mask drives a hazard output so the pipeline stalls on RAW/WAW against buffered results.
- Sits between the write-register select mux / writeback mux and the registers module.

Parameters:
DATA_W, 32, register data width
DEPTH, 2, auxiliary FIFO entries (power of two, >=2)
MAX_WAIT, 4, cycles the FIFO head may wait before stall_req asserts

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
main_we  in  1  main writeback write enable
main_addr  in  5  main write register (from write-register mux)
main_data  in  DATA_W  main writeback data
aux_valid  in  1  auxiliary result valid
aux_ready  out  1  FIFO can accept an auxiliary result
aux_addr  in  5  auxiliary destination register
aux_data  in  DATA_W  auxiliary result data
rs_addr  in  5  decode-stage source register 1
rt_addr  in  5  decode-stage source register 2
rd_addr  in  5  decode-stage destination register
hazard  out  1  decode operand or destination is pending in the FIFO
stall_req  out  1  pipeline must hold main_we=0 next cycle
rf_we  out  1  register file write enable
rf_addr  out  5  register file write address
rf_data  out  DATA_W  register file write data

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - rf_we=0, rf_addr=0, rf_data=0, stall_req=0.
  - FIFO empty, age=0.
  - aux_ready=1 and hazard=0 after reset (both combinational).
- Reset may assert mid-operation: FIFO contents are discarded and outputs go to reset values immediately.
- rf_we, rf_addr and rf_data are registered. Latency is exactly 1 cycle from the selected source to the outputs.
- Issue selection each cycle:
  - If main_we=1 and main_addr!=0, issue main. FIFO does not pop.
  - Else, if FIFO not empty, issue the FIFO head and pop.
  - Else, next rf_we=0; rf_addr and rf_data hold.
  - main_we with main_addr=0 is treated as no main request, so a FIFO slot may issue.
- Auxiliary handshake:
  - aux_ready = !full, from registered state only; no dependence on this cycle's pop.
  - Transfer occurs when aux_valid & aux_ready.
  - aux_addr=0 transfers are accepted and discarded (not enqueued).
  - Push and pop in the same cycle: order preserved, count unchanged.
  - Push while full cannot occur, because aux_ready=0.
- Age counter:
  - Clears on pop or when the FIFO is empty.
  - Otherwise increments each cycle the head is non-empty and not popped, saturating at MAX_WAIT.
  - stall_req = (age==MAX_WAIT), registered.
  - If main_we is still asserted during stall_req, main still wins; age stays saturated.
- Pending mask:
  - 32-bit vector with a bit set for each destination held in the FIFO.
  - A bit clears when its last FIFO entry pops.
  - Bit 0 is never set.
  - The entry issuing on the output register this cycle is no longer pending.
- hazard (combinational) = OR of pend_mask[rs_addr], pend_mask[rt_addr], pend_mask[rd_addr], each ignored when its address is 0.
- A main write to an address pending in the FIFO is legal but is the pipeline's fault. The arbiter still issues both, main first, with no reordering.
- Pointers wrap modulo DEPTH. Count is DEPTH+1 states, so full and empty are distinguished.

Decomposition:
- Package reg_arb_pkg holds:
  - REG_ADDR_W=5 and ZERO_REG=5'd0.
  - Typedef wb_entry_t {addr[4:0], data[DATA_W-1:0]}.
  - Per-register decode helper for pend_mask.
- One sub-module, wb_fifo: parameterised DEPTH x wb_entry_t with push/pop/full/empty/head outputs and per-entry valid/address taps for mask generation.
- The arbiter holds selection, the age counter, the mask/hazard logic and the output registers.

Test Plan:
- Reset then idle, no requests for 5 cycles -> rf_we=0, aux_ready=1, hazard=0, stall_req=0 throughout.
- main_we=1 addr=8 data=0x1234 while FIFO empty -> next cycle rf_we=1, rf_addr=8, rf_data=0x1234.
- Aux push addr=9 data=0xAAAA during main_we=0 -> rf writes r9=0xAAAA two cycles later; pend_mask[9] set for one cycle; hazard=1 while rs_addr=9 in that window.
- Aux pushes r10 then r11 back-to-back while main_we=1 continuously -> aux_ready=0 after 2 pushes; stall_req asserts after MAX_WAIT=4 cycles of waiting; with main_we dropped, r10 then r11 written in order.
- Aux push with aux_addr=0, and main_we=1 with main_addr=0 in the same cycle -> no enqueue, rf_we=0 next cycle, and no hazard on rd_addr=0.
- rst_n pulsed low mid-cycle with 2 FIFO entries pending -> rf_we=0 immediately, FIFO empty, hazard=0, aux_ready=1; no pending writes issue after release.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Latency: none, declarations only.
// Backpressure: none, no flow control lives here.
package reg_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_DATA_W  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Default writeback entry; the arbiter re-declares it at its own DATA_W.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  // One-hot decode of a destination register. r0 is hardwired and never pending.
  function automatic logic [NUM_REGS-1:0] reg_decode(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] onehot;
    onehot = '0;
    if (addr != ZERO_REG) onehot[addr] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries with per-slot valid/address taps.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: full is raised at DEPTH entries; caller must not push when full or pop when empty.
module wb_fifo
  import reg_arb_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push,
  input  entry_t                               push_entry,
  input  logic                                 pop,
  output logic                                 full,
  output logic                                 empty,
  output entry_t                               head,
  output logic [DEPTH-1:0]                     entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  entry_t [DEPTH-1:0]  mem;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until count marks them valid, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(g) - rd_ptr;
    assign entry_valid[g] = ({1'b0, offset} < count);
    assign entry_addr[g]  = mem[g].addr;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between main writeback (priority) and buffered aux results.
// Latency: 1 cycle from the selected source to rf_we/rf_addr/rf_data.
// Backpressure: aux_ready drops when the FIFO is full; stall_req asks the pipeline to free a slot.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  main_we,
  input  logic [REG_ADDR_W-1:0] main_addr,
  input  logic [DATA_W-1:0]     main_data,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [REG_ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0]     aux_data,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  hazard,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } entry_t;

  logic                             main_req;
  logic                             push;
  logic                             pop;
  logic                             fifo_full;
  logic                             fifo_empty;
  entry_t                           push_entry;
  entry_t                           head;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
  logic [NUM_REGS-1:0]              pend_mask;
  logic [AGE_W-1:0]                 age;
  logic [AGE_W-1:0]                 age_nxt;

  // A main write to r0 is no write at all, so it must not block a FIFO drain.
  assign main_req   = main_we && (main_addr != ZERO_REG);
  assign aux_ready  = !fifo_full;
  // Aux results for r0 complete the handshake but are dropped.
  assign push       = aux_valid && aux_ready && (aux_addr != ZERO_REG);
  assign pop        = !main_req && !fifo_empty;
  assign push_entry = {aux_addr, aux_data};

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (head),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Pending destinations are exactly the live FIFO slots; bit 0 stays clear by decode.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pend_mask = pend_mask | reg_decode(entry_addr[i]);
    end
  end

  // r0 operands never hazard because pend_mask[0] is never set.
  assign hazard = pend_mask[rs_addr] | pend_mask[rt_addr] | pend_mask[rd_addr];

  // Head wait time: restart on pop or empty, otherwise count up and saturate.
  always_comb begin
    age_nxt = age;
    if (fifo_empty || pop) begin
      age_nxt = '0;
    end else if (age != AGE_W'(MAX_WAIT)) begin
      age_nxt = age + AGE_W'(1);
    end
  end

  // Age and its stall flag move together so stall_req always reflects the current age.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age       <= '0;
      stall_req <= 1'b0;
    end else begin
      age       <= age_nxt;
      stall_req <= (age_nxt == AGE_W'(MAX_WAIT));
    end
  end

  // Write-port register: main first, then FIFO head; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (main_req) begin
      rf_we   <= 1'b1;
      rf_addr <= main_addr;
      rf_data <= main_data;
    end else if (pop) begin
      rf_we   <= 1'b1;
      rf_addr <= head.addr;
      rf_data <= head.data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a queue-based reference model.
// Latency: checks registered outputs one cycle after the driving inputs.
// Backpressure: model tracks FIFO fullness to predict aux_ready and stall_req.
module tb_reg_write_arbiter;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              main_we;
  logic [4:0]        main_addr;
  logic [DATA_W-1:0] main_data;
  logic              aux_valid;
  logic              aux_ready;
  logic [4:0]        aux_addr;
  logic [DATA_W-1:0] aux_data;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [4:0]        rd_addr;
  logic              hazard;
  logic              stall_req;
  logic              rf_we;
  logic [4:0]        rf_addr;
  logic [DATA_W-1:0] rf_data;

  reg_write_arbiter #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .main_we   (main_we),
    .main_addr (main_addr),
    .main_data (main_data),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_addr  (aux_addr),
    .aux_data  (aux_data),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .hazard    (hazard),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a plain queue; head wait is measured in elapsed cycles.
  typedef struct {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  logic              m_we;
  logic [4:0]        m_addr;
  logic [DATA_W-1:0] m_data;
  int                cyc;
  int                head_since;
  int                n_cmp;
  int                n_bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    head_since = cyc;
  endtask

  task automatic check_all();
    logic exp_stall;
    exp_stall = (q.size() != 0) && ((cyc - head_since) >= MAX_WAIT);
    check_eq("rf_we", rf_we, m_we);
    check_eq("rf_addr", rf_addr, m_addr);
    check_eq("rf_data", rf_data, m_data);
    check_eq("stall_req", stall_req, exp_stall);
    check_eq("aux_ready", aux_ready, q.size() < DEPTH);
    check_eq("hazard", hazard, is_pending(rs_addr) | is_pending(rt_addr) | is_pending(rd_addr));
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_step();
    logic had;
    logic popped;
    logic pushing;
    ent_t e;
    had     = (q.size() != 0);
    popped  = 1'b0;
    pushing = aux_valid && (q.size() < DEPTH) && (aux_addr != 5'd0);
    if (main_we && main_addr != 5'd0) begin
      m_we   = 1'b1;
      m_addr = main_addr;
      m_data = main_data;
    end else if (had) begin
      e      = q.pop_front();
      popped = 1'b1;
      m_we   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
    end else begin
      m_we   = 1'b0;
    end
    if (pushing) begin
      e.addr = aux_addr;
      e.data = aux_data;
      q.push_back(e);
    end
    if (popped || !had) head_since = cyc + 1;
    cyc++;
  endtask

  task automatic set_in(input logic we, input logic [4:0] ma, input logic [DATA_W-1:0] md,
                        input logic av, input logic [4:0] aa, input logic [DATA_W-1:0] ad,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    main_we   = we;
    main_addr = ma;
    main_data = md;
    aux_valid = av;
    aux_addr  = aa;
    aux_data  = ad;
    rs_addr   = rs;
    rt_addr   = rt;
    rd_addr   = rd;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (5) tick();

    // Main write with an empty FIFO.
    set_in(1, 5'd8, 32'h1234, 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("main_we", rf_we, 1);
    check_eq("main_addr", rf_addr, 8);
    check_eq("main_data", rf_data, 32'h1234);

    // Single aux result into an idle slot, with decode reading r9.
    set_in(0, 0, 0, 1, 5'd9, 32'hAAAA, 5'd9, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 5'd9, 0, 0);
    #1;
    check_eq("hazard_r9", hazard, 1);
    tick();
    check_eq("aux_r9_we", rf_we, 1);
    check_eq("aux_r9_addr", rf_addr, 9);
    check_eq("aux_r9_data", rf_data, 32'hAAAA);
    tick();

    // Two aux results queued behind continuous main writes, then starvation.
    set_in(1, 5'd3, 32'h3333, 1, 5'd10, 32'h1010, 5'd10, 5'd11, 0);
    tick();
    set_in(1, 5'd4, 32'h4444, 1, 5'd11, 32'h1111, 5'd10, 5'd11, 0);
    tick();
    check_eq("ready_full", aux_ready, 0);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'(5 + i), $urandom, 1, 5'd12, 32'hDEAD, 5'd10, 5'd11, 0);
      tick();
    end
    check_eq("stall_sat", stall_req, 1);
    set_in(1, 5'd7, 32'h7777, 0, 0, 0, 5'd10, 5'd11, 0);
    tick();
    check_eq("stall_held", stall_req, 1);
    set_in(0, 0, 0, 0, 0, 0, 5'd10, 5'd11, 0);
    tick();
    check_eq("drain_r10", rf_addr, 10);
    tick();
    check_eq("drain_r11", rf_addr, 11);
    tick();

    // r0 on both sources in the same cycle.
    set_in(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hEEEE, 0, 0, 0);
    tick();
    check_eq("r0_no_write", rf_we, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset with two entries pending.
    set_in(1, 5'd1, 32'h1, 1, 5'd12, 32'hC0C0, 5'd12, 5'd13, 0);
    tick();
    set_in(1, 5'd2, 32'h2, 1, 5'd13, 32'hD0D0, 5'd12, 5'd13, 0);
    tick();
    set_in(1, 5'd3, 32'h3, 0, 0, 0, 5'd12, 5'd13, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 5'd12, 5'd13, 0);
    reset_pulse();
    repeat (4) tick();

    // Randomized traffic with phases of light and heavy main writeback.
    for (int i = 0; i < 3000; i++) begin
      int pct;
      pct = ((i / 200) % 3 == 0) ? 20 : (((i / 200) % 3 == 1) ? 50 : 95);
      set_in($urandom_range(0, 99) < pct,
             ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
             $urandom,
             $urandom_range(0, 1),
             5'($urandom_range(0, 7)),
             $urandom,
             5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)));
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse();
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
